// File: rtl/regfile_write_port.sv
// rtl/regfile_write_port.sv - register file write side: staged write, one-hot commit, clear sweep
module regfile_write_port #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  pend_valid,
  output logic [4:0]            pend_addr,
  output logic [WIDTH-1:0]      pend_data,
  output logic                  wr_done,
  output logic [32*WIDTH-1:0]   regs_flat
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]  state;
  logic [4:0]  idx;
  logic        accept;
  logic [31:1] wr_en;
  logic [31:1] clr_en;

  // A clear request blocks acceptance in the same cycle, so clear wins a tie.
  assign wr_ready = (state == IDLE) && !clr_req;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state == CLEAR);

  // Clear-sweep sequencer: idx walks 1..31, returning to IDLE on the edge that zeroes reg 31.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state <= IDLE;
      idx   <= 5'd1;
    end else if (state == IDLE) begin
      if (clr_req) begin
        state <= CLEAR;
        idx   <= 5'd1;
      end
    end else begin
      if (idx == 5'd31) begin
        state <= IDLE;
        idx   <= 5'd1;
      end else begin
        idx <= idx + 5'd1;
      end
    end
  end

  // Stage register: one entry, always drained the following edge; wr_done trails the commit.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= 5'd0;
      pend_data  <= '0;
      wr_done    <= 1'b0;
    end else begin
      pend_valid <= accept;
      wr_done    <= pend_valid;
      if (accept) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  // One-hot decode of the commit address and of the sweep index; entry 0 has no enable.
  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int i = 1; i < 32; i++) begin
      wr_en[i]  = pend_valid && (pend_addr == 5'(i));
      clr_en[i] = (state == CLEAR) && (idx == 5'(i));
    end
  end

  assign regs_flat[WIDTH-1:0] = '0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [WIDTH-1:0] r;

    // Storage register g: sweep zeroing takes priority over a commit.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
        r <= '0;
      end else if (clr_en[g]) begin
        r <= '0;
      end else if (wr_en[g]) begin
        r <= pend_data;
      end
    end

    assign regs_flat[g*WIDTH +: WIDTH] = r;
  end

endmodule

// File: tb/tb_regfile_write_port.sv
// tb/tb_regfile_write_port.sv - scoreboard bench for regfile_write_port
module tb_regfile_write_port;

  logic          clock;
  logic          ctrl_reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          busy;
  logic          pend_valid;
  logic [4:0]    pend_addr;
  logic [31:0]   pend_data;
  logic          wr_done;
  logic [1023:0] regs_flat;

  regfile_write_port #(.WIDTH(32)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .clr_req      (clr_req),
    .busy         (busy),
    .pend_valid   (pend_valid),
    .pend_addr    (pend_addr),
    .pend_data    (pend_data),
    .wr_done      (wr_done),
    .regs_flat    (regs_flat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          cur_run  = 0;
  int          max_run  = 0;
  logic [36:0] sb[$];
  logic [31:0] model[32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int i);
    return regs_flat[i*32 +: 32];
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", tag, i), get_reg(i), model[i]);
  endtask

  task automatic model_zero();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one accepted write for a single edge; caller deasserts wr_valid.
  task automatic drive(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    check("wr_ready_on_write", wr_ready, 1);
    sb.push_back({a, d});
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Scoreboard consumer: every wr_done pops the oldest accepted write and checks its slot.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clock);
      if (wr_done) begin
        done_cnt++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (sb.size() == 0) begin
          check("spurious_wr_done", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e[36:32] != 5'd0) model[e[36:32]] = e[31:0];
          check($sformatf("commit_r%0d", e[36:32]), get_reg(int'(e[36:32])),
                (e[36:32] == 5'd0) ? 32'h0 : e[31:0]);
        end
      end else begin
        cur_run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int guard;
    int d0;

    ctrl_reset_n = 1'b0;
    wr_valid     = 1'b0;
    wr_addr      = 5'd0;
    wr_data      = 32'h0;
    clr_req      = 1'b0;
    model_zero();
    idle(2);

    check_all("reset");
    check("reset_busy", busy, 0);
    check("reset_wr_done", wr_done, 0);
    check("reset_pend_valid", pend_valid, 0);
    check("reset_pend_addr", pend_addr, 0);
    check("reset_pend_data", pend_data, 0);
    check("reset_wr_ready", wr_ready, 1);
    ctrl_reset_n = 1'b1;
    idle(1);

    // Single write to reg 5
    d0 = done_cnt;
    drive(5'd5, 32'hDEADBEEF);
    wr_valid = 1'b0;
    check("w5_pend_valid", pend_valid, 1);
    check("w5_pend_addr", pend_addr, 5);
    check("w5_pend_data", pend_data, 32'hDEADBEEF);
    idle(1);
    check("w5_pend_cleared", pend_valid, 0);
    check("w5_reg", get_reg(5), 32'hDEADBEEF);
    idle(2);
    check("w5_done_count", done_cnt - d0, 1);
    check_all("w5");

    // Write to reg 0 is dropped but still acknowledged
    d0 = done_cnt;
    drive(5'd0, 32'hFFFFFFFF);
    wr_valid = 1'b0;
    idle(3);
    check("w0_reg0", get_reg(0), 0);
    check("w0_done_count", done_cnt - d0, 1);
    check_all("w0");

    // Back-to-back writes, same address twice
    d0 = done_cnt;
    max_run = 0;
    drive(5'd7, 32'h1);
    drive(5'd7, 32'h2);
    drive(5'd8, 32'h3);
    wr_valid = 1'b0;
    idle(4);
    check("b2b_reg7", get_reg(7), 32'h2);
    check("b2b_reg8", get_reg(8), 32'h3);
    check("b2b_done_count", done_cnt - d0, 3);
    check("b2b_done_run", max_run, 3);

    // Fill 1..31, then clear colliding with a write
    for (int i = 1; i < 32; i++) drive(5'(i), 32'(i));
    wr_valid = 1'b0;
    idle(3);
    check_all("fill");
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'hAA;
    #1;
    check("clr_refuses_write", wr_ready, 0);
    @(negedge clock);
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    c = 0;
    guard = 0;
    while (busy && guard < 100) begin
      c++;
      guard++;
      check("sweep_ready_low", wr_ready, 0);
      if (c <= 31) check($sformatf("sweep_pending_r%0d", c), get_reg(c), 32'(c));
      if (c >= 2 && c <= 32) check($sformatf("sweep_cleared_r%0d", c - 1), get_reg(c - 1), 0);
      @(negedge clock);
    end
    check("sweep_busy_cycles", c, 31);
    check("sweep_ready_after", wr_ready, 1);
    model_zero();
    check_all("swept");

    // Pending write at CLEAR entry commits, then reset lands mid-sweep at idx 12
    drive(5'd20, 32'h77);
    drive(5'd31, 32'h99);
    drive(5'd6, 32'h66);
    wr_valid = 1'b0;
    clr_req  = 1'b1;
    @(negedge clock);
    clr_req = 1'b0;
    idle(11);
    check("mid_sweep_busy", busy, 1);
    check("mid_sweep_r20", get_reg(20), 32'h77);
    check("mid_sweep_r6", get_reg(6), 32'h0);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    model_zero();
    check("rst_sweep_busy", busy, 0);
    check("rst_sweep_pend", pend_valid, 0);
    check_all("rst_sweep");
    idle(1);
    ctrl_reset_n = 1'b1;
    #1;
    check("rst_sweep_ready", wr_ready, 1);
    idle(1);

    // Reset while a write is staged: discarded, no wr_done
    d0 = done_cnt;
    drive(5'd9, 32'h5A5A5A5A);
    wr_valid = 1'b0;
    check("staged_pend_valid", pend_valid, 1);
    #2;
    ctrl_reset_n = 1'b0;
    sb.delete();
    #1;
    check("staged_rst_pend", pend_valid, 0);
    check("staged_rst_done", wr_done, 0);
    idle(2);
    ctrl_reset_n = 1'b1;
    idle(2);
    check("staged_rst_no_done", done_cnt - d0, 0);
    check_all("staged_rst");

    // Normal operation after reset release
    d0 = done_cnt;
    drive(5'd4, 32'h1234);
    wr_valid = 1'b0;
    idle(3);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_r4", get_reg(4), 32'h1234);
    check("sb_drained", sb.size(), 0);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
